// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, write-back, write-allocate cache controller with one-word lines.
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   cpuReq/cpuWe        CPU request valid and write strobe, sampled only in IDLE
//   cpuAddr/cpuWdata    CPU word address and write data
//   cpuRdata/cpuDone    read data and its one-cycle completion pulse
//   cpuBusy             high whenever the controller is not in IDLE
//   rwToBus             bus command (IDEL/RD/WT)
//   addrToBus/dataToBus bus address and write-back data, stable from request through completion
//   dataFromBus         fill data, valid when rdEnFromBus rises
//   rdEnFromBus         read handshake (low = busy, high = idle/done)
//   wbDoneFromBus       write handshake (low = busy, high = idle/done)
//   hitCnt/missCnt      saturating hit and miss counters
module cache_ctrl #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 8,
    parameter int IDX_W  = 2,
    parameter int IO_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [WORD_W-1:0] cpuWdata,
    output logic [WORD_W-1:0] cpuRdata,
    output logic              cpuDone,
    output logic              cpuBusy,
    output logic [IO_W-1:0]   rwToBus,
    output logic [ADDR_W-1:0] addrToBus,
    output logic [WORD_W-1:0] dataToBus,
    input  logic [WORD_W-1:0] dataFromBus,
    input  logic              rdEnFromBus,
    input  logic              wbDoneFromBus,
    output logic [7:0]        hitCnt,
    output logic [7:0]        missCnt
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam logic [IO_W-1:0] IDEL = IO_W'(0);
    localparam logic [IO_W-1:0] RD   = IO_W'(1);
    localparam logic [IO_W-1:0] WT   = IO_W'(2);

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP} state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [WORD_W-1:0] data_mem [LINES];
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [WORD_W-1:0] lat_wdata;
    logic              wb_prev;
    logic              rd_prev;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] lat_idx;
    logic [TAG_W-1:0] lat_tag;
    logic             hit;

    assign idx     = cpuAddr[IDX_W-1:0];
    assign tag     = cpuAddr[ADDR_W-1:IDX_W];
    assign lat_idx = lat_addr[IDX_W-1:0];
    assign lat_tag = lat_addr[ADDR_W-1:IDX_W];
    assign hit     = valid[idx] && (tag_mem[idx] == tag);
    assign cpuBusy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= '0;
            end
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            // Previous handshake levels start low so a bus that is already
            // busy is never mistaken for a fresh acceptance.
            wb_prev   <= 1'b0;
            rd_prev   <= 1'b0;
            cpuRdata  <= '0;
            cpuDone   <= 1'b0;
            rwToBus   <= IDEL;
            addrToBus <= '0;
            dataToBus <= '0;
            hitCnt    <= '0;
            missCnt   <= '0;
        end else begin
            wb_prev <= wbDoneFromBus;
            rd_prev <= rdEnFromBus;
            cpuDone <= 1'b0;
            case (state)
                IDLE: if (cpuReq) begin
                    lat_addr  <= cpuAddr;
                    lat_we    <= cpuWe;
                    lat_wdata <= cpuWdata;
                    if (hit) begin
                        if (cpuWe) begin
                            data_mem[idx] <= cpuWdata;
                            dirty[idx]    <= 1'b1;
                        end
                        cpuRdata <= cpuWe ? cpuWdata : data_mem[idx];
                        cpuDone  <= 1'b1;
                        hitCnt   <= hitCnt + {7'd0, hitCnt != 8'hFF};
                    end else begin
                        missCnt <= missCnt + {7'd0, missCnt != 8'hFF};
                        if (valid[idx] && dirty[idx]) begin
                            state     <= WB_REQ;
                            rwToBus   <= WT;
                            addrToBus <= {tag_mem[idx], idx};
                            dataToBus <= data_mem[idx];
                        end else begin
                            state     <= FILL_REQ;
                            rwToBus   <= RD;
                            addrToBus <= cpuAddr;
                        end
                    end
                end
                // Acceptance is the falling edge of the handshake while the
                // command is still driven; dropping to IDEL right away keeps
                // the bus from accepting the same request twice.
                WB_REQ: if (wb_prev && !wbDoneFromBus) begin
                    rwToBus <= IDEL;
                    state   <= WB_WAIT;
                end
                WB_WAIT: if (wbDoneFromBus) begin
                    dirty[lat_idx] <= 1'b0;
                    rwToBus        <= RD;
                    addrToBus      <= lat_addr;
                    state          <= FILL_REQ;
                end
                FILL_REQ: if (rd_prev && !rdEnFromBus) begin
                    rwToBus <= IDEL;
                    state   <= FILL_WAIT;
                end
                FILL_WAIT: if (rdEnFromBus) begin
                    valid[lat_idx]    <= 1'b1;
                    dirty[lat_idx]    <= 1'b0;
                    tag_mem[lat_idx]  <= lat_tag;
                    data_mem[lat_idx] <= dataFromBus;
                    state             <= RESP;
                end
                RESP: begin
                    if (lat_we) begin
                        data_mem[lat_idx] <= lat_wdata;
                        dirty[lat_idx]    <= 1'b1;
                    end
                    cpuRdata <= lat_we ? lat_wdata : data_mem[lat_idx];
                    cpuDone  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
